vlc_lookup_pipe: RTL and testbench

Parametrised VLC code lookup stage for the Huffman encoder path. Accepts literal symbols with a valid/ready handshake and addresses an external synchronous code table. Each returned table word is checked and pushed into an internal first-word-fall-through FIFO that feeds the bit packer. Over the fixed 8-bit/16-deep lookup it adds:
- real backpressure;
- a symbol-stream `last` marker;
- clearable error reporting;
- flush.

---
 rtl/vlc_pkg.sv | 24 ++
 rtl/vlc_sync_fifo.sv | 59 +++++
 rtl/vlc_lookup_pipe.sv | 138 +++++++++++++
 tb/tb_vlc_lookup_pipe.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vlc_pkg.sv
// Shared widths, table-word field offsets and FSM encoding for the VLC lookup stage.
package vlc_pkg;

  localparam int SYM_W_D  = 8;
  localparam int CODE_W_D = 15;
  localparam int LEN_W_D  = 4;
  localparam int DEPTH_D  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } vlc_state_e;

  // Table word is {len, ovf, code}; code sits at bit 0.
  function automatic int ovf_bit(input int code_w);
    return code_w;
  endfunction

  function automatic int len_lsb(input int code_w);
    return code_w + 1;
  endfunction

endpackage

// File: rtl/vlc_sync_fifo.sv
// First-word-fall-through register-array FIFO with synchronous clear.
module vlc_sync_fifo #(
  parameter int W     = 21,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [W-1:0]  mem [DEPTH];
  logic          push;
  logic          pop;

  assign empty = (fill == '0);
  assign full  = (fill == (AW+1)'(DEPTH));
  assign pop   = rd_en & ~empty;
  assign push  = wr_en & (~full | pop);

  // Head is forced to zero when empty so the outputs read 0 out of reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fill <= fill + (AW+1)'(1);
        2'b01:   fill <= fill - (AW+1)'(1);
        default: fill <= fill;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible between write and pop.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/vlc_lookup_pipe.sv
// VLC code lookup stage: symbol in, synchronous table lookup, checked entry into a FWFT FIFO.
// Handshake: a symbol transfers on any rising edge where src_valid && src_ready; src_ready
// depends only on registered state, never on same-cycle src_valid or rd_code.
module vlc_lookup_pipe
  import vlc_pkg::*;
#(
  parameter int SYM_W  = SYM_W_D,
  parameter int CODE_W = CODE_W_D,
  parameter int LEN_W  = LEN_W_D,
  parameter int DEPTH  = DEPTH_D,
  parameter int ENT_W  = LEN_W + 1 + CODE_W
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic [SYM_W-1:0]         src_data,
  input  logic                     src_valid,
  input  logic                     src_last,
  output logic                     src_ready,
  output logic [SYM_W-1:0]         vlc_addr,
  input  logic [ENT_W-1:0]         vlc_data,
  input  logic                     flush,
  input  logic                     err_clr,
  output logic                     error,
  output logic [7:0]               err_cnt,
  output logic                     busy,
  input  logic                     rd_code,
  output logic [LEN_W-1:0]         code_len,
  output logic                     code_ovf,
  output logic [CODE_W-1:0]        code_data,
  output logic                     code_last,
  output logic                     code_valid,
  output logic                     code_empty,
  output logic                     code_full,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [1:0]               state_dbg
);

  localparam int FW    = $clog2(DEPTH) + 1;
  localparam int OVF_B = ovf_bit(CODE_W);
  localparam int LEN_L = len_lsb(CODE_W);

  vlc_state_e     state;
  vlc_state_e     state_nxt;
  logic           pend;
  logic           last_q;
  logic           accept;
  logic           wr_en;
  logic           bad_wr;
  logic           room;
  logic           fifo_empty;
  logic           fifo_full;
  logic [FW-1:0]  fifo_fill;
  logic [ENT_W:0] fifo_rd_data;

  assign vlc_addr = src_data;
  assign accept   = src_valid & src_ready;

  // The word returning in a flush cycle belongs to a discarded lookup.
  assign wr_en  = pend & ~flush;
  assign bad_wr = wr_en & (vlc_data[OVF_B] | (vlc_data[LEN_L +: LEN_W] == '0));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_FLUSH;
    end else begin
      case (state)
        ST_IDLE:  if (accept) state_nxt = ST_RUN;
        ST_RUN:   if (!pend && fifo_empty && !accept) state_nxt = ST_IDLE;
        ST_FLUSH: state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Room counts the in-flight lookup so a full FIFO can never be written.
  always_comb begin
    room      = ({1'b0, fifo_fill} + (FW+1)'(pend)) < (FW+1)'(DEPTH);
    src_ready = (state != ST_FLUSH) && room;
    busy      = (state != ST_IDLE);
    state_dbg = state;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pend   <= 1'b0;
      last_q <= 1'b0;
    end else begin
      pend <= flush ? 1'b0 : accept;
      if (accept) last_q <= src_last;
    end
  end

  // err_clr loses to a bad write in the same cycle, which restarts the count at one.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      error   <= 1'b0;
      err_cnt <= 8'd0;
    end else if (err_clr) begin
      error   <= bad_wr;
      err_cnt <= bad_wr ? 8'd1 : 8'd0;
    end else if (bad_wr) begin
      error <= 1'b1;
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  vlc_sync_fifo #(
    .W     (ENT_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstN    (rstN),
    .clear   (flush),
    .wr_en   (wr_en),
    .wr_data ({vlc_data, last_q}),
    .rd_en   (rd_code),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .fill    (fifo_fill)
  );

  assign code_last  = fifo_rd_data[0];
  assign code_data  = fifo_rd_data[1 +: CODE_W];
  assign code_ovf   = fifo_rd_data[1 + OVF_B];
  assign code_len   = fifo_rd_data[1 + LEN_L +: LEN_W];
  assign code_valid = ~fifo_empty;
  assign code_empty = fifo_empty;
  assign code_full  = fifo_full;
  assign fill       = fifo_fill;

endmodule

// File: tb/tb_vlc_lookup_pipe.sv
// Bench for vlc_lookup_pipe: queue-based reference model checked every cycle plus directed literals.
module tb_vlc_lookup_pipe;

  localparam int SYM_W  = 8;
  localparam int CODE_W = 15;
  localparam int LEN_W  = 4;
  localparam int DEPTH  = 16;
  localparam int ENT_W  = LEN_W + 1 + CODE_W;
  localparam int FW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rstN;
  logic [SYM_W-1:0]  src_data;
  logic              src_valid;
  logic              src_last;
  logic              src_ready;
  logic [SYM_W-1:0]  vlc_addr;
  logic [ENT_W-1:0]  vlc_data;
  logic              flush;
  logic              err_clr;
  logic              error;
  logic [7:0]        err_cnt;
  logic              busy;
  logic              rd_code;
  logic [LEN_W-1:0]  code_len;
  logic              code_ovf;
  logic [CODE_W-1:0] code_data;
  logic              code_last;
  logic              code_valid;
  logic              code_empty;
  logic              code_full;
  logic [FW-1:0]     fill;
  logic [1:0]        state_dbg;

  vlc_lookup_pipe dut (
    .clk(clk), .rstN(rstN),
    .src_data(src_data), .src_valid(src_valid), .src_last(src_last), .src_ready(src_ready),
    .vlc_addr(vlc_addr), .vlc_data(vlc_data),
    .flush(flush), .err_clr(err_clr), .error(error), .err_cnt(err_cnt), .busy(busy),
    .rd_code(rd_code), .code_len(code_len), .code_ovf(code_ovf), .code_data(code_data),
    .code_last(code_last), .code_valid(code_valid), .code_empty(code_empty),
    .code_full(code_full), .fill(fill), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / table memory ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [ENT_W-1:0] tbl [256];
  always @(posedge clk) vlc_data <= tbl[vlc_addr];

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [ENT_W:0] exp_q[$];
  bit             m_pend;
  logic [ENT_W:0] m_word;
  bit             m_err;
  int             m_cnt;
  bit             m_flush_st;
  bit             m_busy;

  logic [SYM_W-1:0] sq_sym[$];
  bit               sq_last[$];
  int               vld_prob;
  int               rd_prob;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [ENT_W-1:0] mkw(input logic [3:0] l, input logic o, input logic [14:0] c);
    return {l, o, c};
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_src_ready"}, src_ready, 1);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_code_valid"}, code_valid, 0);
    chk({tag, "_code_empty"}, code_empty, 1);
    chk({tag, "_code_full"}, code_full, 0);
    chk({tag, "_fill"}, fill, 0);
    chk({tag, "_code_last"}, code_last, 0);
    chk({tag, "_code_len"}, code_len, 0);
    chk({tag, "_code_ovf"}, code_ovf, 0);
    chk({tag, "_code_data"}, code_data, 0);
  endtask

  // ---------------- compare process + reference model ----------------
  logic [ENT_W:0] c_head;
  bit             c_rdy, c_acc, c_pop, c_wr, c_bad, c_busy_n;

  always @(negedge clk) begin
    if (!rstN) begin
      chk_reset_vals("rst");
      exp_q.delete();
      m_pend = 0; m_word = '0; m_err = 0; m_cnt = 0; m_flush_st = 0; m_busy = 0;
    end else begin
      c_head = (exp_q.size() > 0) ? exp_q[0] : '0;
      c_rdy  = !m_flush_st && (exp_q.size() + int'(m_pend) < DEPTH);
      chk("src_ready", src_ready, c_rdy);
      chk("fill", fill, exp_q.size());
      chk("code_valid", code_valid, exp_q.size() != 0);
      chk("code_empty", code_empty, exp_q.size() == 0);
      chk("code_full", code_full, exp_q.size() == DEPTH);
      chk("code_len", code_len, c_head[20:17]);
      chk("code_ovf", code_ovf, c_head[16]);
      chk("code_data", code_data, c_head[15:1]);
      chk("code_last", code_last, c_head[0]);
      chk("error", error, m_err);
      chk("err_cnt", err_cnt, m_cnt);
      chk("busy", busy, m_busy);
      chk("vlc_addr", vlc_addr, src_data);

      c_acc = src_valid && c_rdy;
      c_pop = rd_code && (exp_q.size() > 0);
      c_wr  = m_pend && !flush;
      c_bad = c_wr && (m_word[20:17] == 4'd0 || m_word[16]);
      if (c_wr) chk("ovf_guard", code_full && !c_pop, 0);
      c_busy_n = flush || (!m_flush_st && (c_acc || m_pend || exp_q.size() > 0));

      if (flush) begin
        exp_q.delete();
        m_pend = 0;
      end else begin
        if (c_pop) void'(exp_q.pop_front());
        if (c_wr)  exp_q.push_back(m_word);
        m_pend = c_acc;
        if (c_acc) m_word = {tbl[src_data], src_last};
      end

      if (err_clr) begin
        m_err = c_bad;
        m_cnt = c_bad ? 1 : 0;
      end else if (c_bad) begin
        m_err = 1;
        if (m_cnt < 255) m_cnt++;
      end
      m_busy     = c_busy_n;
      m_flush_st = flush;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_sym(input int s, input bit l);
    sq_sym.push_back(SYM_W'(s));
    sq_last.push_back(l);
  endtask

  task automatic step(input bit fl = 1'b0, input bit ec = 1'b0);
    bit acc;
    if (sq_sym.size() > 0 && $urandom_range(99) < vld_prob) begin
      src_valid = 1'b1;
      src_data  = sq_sym[0];
      src_last  = sq_last[0];
    end else begin
      src_valid = 1'b0;
      src_data  = SYM_W'($urandom_range(255));
      src_last  = 1'($urandom_range(1));
    end
    rd_code = ($urandom_range(99) < rd_prob);
    flush   = fl;
    err_clr = ec;
    @(negedge clk);
    acc = src_valid && src_ready;
    @(posedge clk);
    #1;
    if (acc && sq_sym.size() > 0) begin
      void'(sq_sym.pop_front());
      void'(sq_last.pop_front());
    end
    flush   = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstN = 1'b0; src_valid = 1'b0; src_data = '0; src_last = 1'b0;
    rd_code = 1'b0; flush = 1'b0; err_clr = 1'b0;
    vld_prob = 100; rd_prob = 0;
    for (int s = 0; s < 256; s++) tbl[s] = mkw(4'h5, 1'b0, 15'(s));
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;

    // Fill to 16 without reads.
    for (int i = 0; i < 16; i++) push_sym(i, 1'b0);
    steps(20);
    chk("a_fill16", fill, 16);
    chk("a_ready_low", src_ready, 0);
    chk("a_full", code_full, 1);
    chk("a_head_len", code_len, 5);
    chk("a_head_code", code_data, 0);

    // Sustained 1 in / 1 out from full, then drain.
    for (int i = 16; i < 56; i++) push_sym(i, 1'b0);
    rd_prob = 100;
    steps(45);
    steps(20);
    chk("b_empty", code_empty, 1);
    chk("b_idle", busy, 0);

    // Bad entries: ovf on 0xAA, zero length on 0x55.
    tbl[8'hAA] = mkw(4'h5, 1'b1, 15'h00AA);
    tbl[8'h55] = mkw(4'h0, 1'b0, 15'h0055);
    rd_prob = 0;
    push_sym(8'hAA, 1'b0);
    push_sym(8'h55, 1'b0);
    steps(4);
    chk("c_fill2", fill, 2);
    chk("c_error", error, 1);
    chk("c_cnt2", err_cnt, 2);
    push_sym(8'hAA, 1'b0);
    step();
    step(1'b0, 1'b1);
    chk("c_clr_bad_err", error, 1);
    chk("c_clr_bad_cnt", err_cnt, 1);
    step(1'b0, 1'b1);
    chk("c_clr_err", error, 0);
    chk("c_clr_cnt", err_cnt, 0);
    rd_prob = 100;
    steps(10);

    // Block-end marker in mid-stream.
    rd_prob = 50;
    for (int i = 0; i < 10; i++) push_sym(8'h20 + i, i == 5);
    steps(30);
    rd_prob = 100;
    steps(15);

    // Flush with 7 stored and one lookup in flight.
    rd_prob = 0;
    for (int i = 0; i < 8; i++) push_sym((i == 3) ? 8'hAA : 8'h30 + i, 1'b0);
    steps(8);
    chk("e_fill7", fill, 7);
    step(1'b1);
    chk("e_fill0", fill, 0);
    chk("e_empty", code_empty, 1);
    chk("e_ready_flush", src_ready, 0);
    chk("e_err_kept", error, 1);
    chk("e_cnt_kept", err_cnt, 1);
    step();
    chk("e_ready_after", src_ready, 1);
    chk("e_still_empty", code_empty, 1);
    chk("e_idle", busy, 0);

    // Saturation of err_cnt.
    for (int s = 0; s < 256; s++) tbl[s] = mkw(4'h3, 1'b1, 15'(s));
    rd_prob = 100;
    for (int i = 0; i < 270; i++) push_sym($urandom_range(255), 1'b0);
    steps(280);
    chk("f_sat_cnt", err_cnt, 255);
    chk("f_sat_err", error, 1);
    step(1'b0, 1'b1);
    chk("f_sat_clr", err_cnt, 0);

    // Randomized traffic with random table contents.
    for (int s = 0; s < 256; s++) tbl[s] = ENT_W'($urandom);
    vld_prob = 70; rd_prob = 60;
    for (int i = 0; i < 1200; i++) begin
      if (sq_sym.size() < 4) push_sym($urandom_range(255), $urandom_range(9) == 0);
      step($urandom_range(99) < 2, $urandom_range(99) < 3);
    end
    sq_sym.delete(); sq_last.delete();
    rd_prob = 100; vld_prob = 100;
    steps(25);
    chk("f_drained", code_empty, 1);

    // Asynchronous reset with 9 entries stored.
    for (int s = 0; s < 256; s++) tbl[s] = mkw(4'h7, 1'b0, 15'(s));
    rd_prob = 0;
    for (int i = 0; i < 12; i++) push_sym(8'h40 + i, 1'b0);
    steps(10);
    chk("g_fill9", fill, 9);
    rstN = 1'b0;
    #2;
    chk_reset_vals("g_async");
    sq_sym.delete(); sq_last.delete();
    steps(2);
    rstN = 1'b1;
    rd_prob = 100;
    for (int i = 0; i < 6; i++) push_sym(8'h60 + i, i == 5);
    steps(20);
    chk("g_restart_empty", code_empty, 1);
    chk("g_restart_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
